// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide retire one bit per cycle; special divides can bypass the loop.
module ex_muldiv_unit #(
    parameter int XLEN     = 32,
    parameter bit FASTPATH = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            busy,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int            CW   = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_CALC, S_DONE} state_e;

    state_e            state_q;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   opa_q, opb_q;
    logic [XLEN-1:0]   a_q, b_q, rem_q, result_q;
    logic [2*XLEN-1:0] acc_q, mc_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q, busy_q, done_q;

    logic              is_div, sgn_a, sgn_b, sa, sb, b_zero, ovf, special, neg_prep;
    logic [XLEN-1:0]   abs_a, abs_b, special_res;

    always_comb begin
        is_div = f3_q[2];
        sgn_a  = (f3_q == 3'b001) || (f3_q == 3'b010) || (f3_q == 3'b100) || (f3_q == 3'b110);
        sgn_b  = (f3_q == 3'b001) || (f3_q == 3'b100) || (f3_q == 3'b110);
        sa     = sgn_a & opa_q[XLEN-1];
        sb     = sgn_b & opb_q[XLEN-1];
        abs_a  = sa ? -opa_q : opa_q;
        abs_b  = sb ? -opb_q : opb_q;
        b_zero = (opb_q == '0);
        ovf    = is_div & sgn_b & (opa_q == {1'b1, {(XLEN-1){1'b0}}}) & (opb_q == '1);
        special = is_div & (b_zero | ovf);
        if (b_zero) special_res = f3_q[1] ? opa_q : '1;
        else        special_res = f3_q[1] ? '0 : opa_q;
        // A zero divisor must leave the all-ones quotient un-negated so both paths agree
        if (!is_div)      neg_prep = sa ^ sb;
        else if (f3_q[1]) neg_prep = sa;
        else              neg_prep = (sa ^ sb) & ~b_zero;
    end

    logic [2*XLEN-1:0] acc_d;
    logic [XLEN:0]     div_sh, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   rem_d, quo_d;

    always_comb begin
        acc_d    = b_q[0] ? acc_q + mc_q : acc_q;
        div_sh   = {rem_q, a_q[XLEN-1]};
        div_diff = div_sh - {1'b0, b_q};
        div_ge   = ~div_diff[XLEN];
        rem_d    = div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
        quo_d    = {a_q[XLEN-2:0], div_ge};
    end

    function automatic logic [XLEN-1:0] finalize(input logic [2:0]        f3,
                                                 input logic [2*XLEN-1:0] prod,
                                                 input logic [XLEN-1:0]   quo,
                                                 input logic [XLEN-1:0]   rem,
                                                 input logic              neg);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r;
        p = neg ? -prod : prod;
        q = neg ? -quo : quo;
        r = neg ? -rem : rem;
        case (f3)
            3'b000:                 finalize = p[XLEN-1:0];
            3'b001, 3'b010, 3'b011: finalize = p[2*XLEN-1:XLEN];
            3'b100, 3'b101:         finalize = q;
            default:                finalize = r;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            mc_q     <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (flush) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        f3_q    <= funct3;
                        opa_q   <= op_a;
                        opb_q   <= op_b;
                        busy_q  <= 1'b1;
                        state_q <= S_PREP;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_PREP: begin
                    a_q   <= abs_a;
                    b_q   <= abs_b;
                    mc_q  <= {{XLEN{1'b0}}, abs_a};
                    acc_q <= '0;
                    rem_q <= '0;
                    cnt_q <= '0;
                    neg_q <= neg_prep;
                    if (FASTPATH && special) begin
                        result_q <= special_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div) begin
                        rem_q <= rem_d;
                        a_q   <= quo_d;
                    end else begin
                        acc_q <= acc_d;
                        mc_q  <= mc_q << 1;
                        b_q   <= b_q >> 1;
                    end
                    cnt_q <= cnt_q + CW'(1);
                    // Last iteration folds sign fix-up and selection into the same edge
                    if (cnt_q == LAST) begin
                        result_q <= finalize(f3_q, acc_d, quo_d, rem_d, neg_q);
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign stall_req = busy_q | (start & ((state_q == S_IDLE) || (state_q == S_DONE)) & ~flush);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: stimulus pushes expected results, a monitor checks each done pulse.
module tb_ex_muldiv_unit;
    localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
    localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;
    localparam int LAT_FULL = 33;
    localparam int LAT_FAST = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy, stall_req, done;
    logic [31:0] result;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] exp_q[$];
    int          due_q[$];
    string       tag_q[$];

    ex_muldiv_unit #(.XLEN(32), .FASTPATH(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin : mon
        logic [31:0] e;
        int          d;
        string       t;
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = exp_q.pop_front();
                d = due_q.pop_front();
                t = tag_q.pop_front();
                chk({t, "_result"}, result, e);
                chk({t, "_latency"}, 32'(cyc), 32'(d));
            end
        end
    end

    task automatic issue(input bit sync, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input bit push, input logic [31:0] e,
                         input int lat, input string tag);
        int c;
        if (sync) @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        c      = cyc;
        @(posedge clk);
        if (push) begin
            exp_q.push_back(e);
            due_q.push_back(c + 1 + lat);
            tag_q.push_back(tag);
        end
        #1;
        start  = 1'b0;
        funct3 = 3'($urandom_range(7));
        op_a   = $urandom;
        op_b   = $urandom;
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL %s_timeout: %0d results outstanding after %0d cycles, required 0", tag, exp_q.size(), n);
            exp_q.delete();
            due_q.delete();
            tag_q.delete();
        end
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 80);
        if (!done) begin
            n_chk++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", tag, n);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input int lat, input string tag);
        issue(1'b1, f, a, b, 1'b1, e, lat, tag);
        wait_empty(tag);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit stall_ok;
        int n;

        #1 rst_n = 1'b0;
        #2;
        chk("reset_busy",   32'(busy),      32'd0);
        chk("reset_done",   32'(done),      32'd0);
        chk("reset_stall",  32'(stall_req), 32'd0);
        chk("reset_result", result,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full-latency multiply with stall watched every cycle
        issue(1'b1, F_MUL, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFEB, LAT_FULL, "mul");
        stall_ok = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done && !stall_req) stall_ok = 1'b0;
        end while (!done && n < 80);
        chk("mul_stall", 32'(stall_ok), 32'd1);
        @(negedge clk);
        chk("mul_done_pulse", 32'(done), 32'd0);
        wait_empty("mul");

        run_op(F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_FULL, "mulh_min");
        run_op(F_MULHU,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_FULL, "mulhu_min");
        run_op(F_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, LAT_FULL, "mulhsu");
        run_op(F_MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, LAT_FULL, "mulh_neg");
        run_op(F_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         LAT_FULL, "mul_ones");
        run_op(F_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, LAT_FAST, "divu_zero");
        run_op(F_REMU,   32'd100,       32'd0,         32'd100,       LAT_FAST, "remu_zero");
        run_op(F_DIV,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, LAT_FAST, "div_zero");
        run_op(F_REM,    32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_FAST, "rem_zero");
        run_op(F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_FAST, "div_ovf");
        run_op(F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         LAT_FAST, "rem_ovf");
        run_op(F_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT_FULL, "rem_neg");
        run_op(F_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT_FULL, "div_neg");
        run_op(F_DIV,    32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, LAT_FULL, "div_negb");
        run_op(F_REM,    32'd100,       32'hFFFF_FFF9, 32'd2,         LAT_FULL, "rem_negb");
        run_op(F_REMU,   32'd100,       32'd7,         32'd2,         LAT_FULL, "remu");

        // Start during busy must be ignored
        issue(1'b1, F_DIVU, 32'd1000, 32'd7, 1'b1, 32'd142, LAT_FULL, "divu_busy");
        repeat (5) @(negedge clk);
        start = 1'b1; funct3 = F_MUL; op_a = 32'd2; op_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        wait_empty("divu_busy");

        // Back-to-back starts in the DONE cycle
        issue(1'b1, F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, LAT_FULL, "b2b_mulhu");
        wait_done("b2b_mulhu");
        issue(1'b0, F_REMU, 32'd100, 32'd0, 1'b1, 32'd100, LAT_FAST, "b2b_remu");
        wait_done("b2b_remu");
        issue(1'b0, F_DIVU, 32'd100, 32'd7, 1'b1, 32'd14, LAT_FULL, "b2b_divu");
        wait_empty("b2b_divu");

        // Flush at CALC iteration 10
        issue(1'b1, F_DIVU, 32'd1000, 32'd7, 1'b0, 32'd0, LAT_FULL, "flush_op");
        repeat (12) @(negedge clk);
        chk("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy",  32'(busy),      32'd0);
        chk("flush_stall", 32'(stall_req), 32'd0);
        repeat (40) @(negedge clk);
        run_op(F_DIVU, 32'd9, 32'd3, 32'd3, LAT_FULL, "divu_after_flush");

        // Flush beats start in the same cycle; result is retained
        @(negedge clk);
        start = 1'b1; flush = 1'b1; funct3 = F_MUL; op_a = 32'd5; op_b = 32'd5;
        #1;
        chk("flush_start_stall", 32'(stall_req), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        chk("flush_keep_result", result, 32'd3);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of CALC
        issue(1'b1, F_MUL, 32'd3, 32'd5, 1'b0, 32'd0, LAT_FULL, "rst_op");
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy",   32'(busy),      32'd0);
        chk("rst_mid_done",   32'(done),      32'd0);
        chk("rst_mid_stall",  32'(stall_req), 32'd0);
        chk("rst_mid_result", result,         32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);

        run_op(F_MUL, 32'h1234_5678, 32'd16, 32'h2345_6780, LAT_FULL, "mul_final");
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
